enc_cnt_multi: RTL and testbench
================================

# enc_cnt_multi

Parametrised multi-channel incremental-encoder pulse counter; next generation of the fixed two-channel, 64-bit encoder counter top. Each channel counts A-pulse rising edges between successive Z (index) pulses while globally armed, captures the per-revolution count on every Z, and flags saturation. Sits between the encoder input pins and the DAQ readout logic; a registered select mux provides single-channel readback.

## Interface
- P_CH, 2: number of encoder channels, 1..16
- P_CW, 64: counter/capture width in bits, 8..64
- P_SW, max(1,$clog2(P_CH)): select width (derived, not overridable)

- CLK  in  1  system clock (128 MHz nominal)
- RST  in  1  reset, synchronous, active-high
- I_ARM  in  1  global arm, level; shared by all channels
- I_A  in  P_CH  encoder A pulses, one bit per channel
- I_Z  in  P_CH  encoder index pulses, one bit per channel
- I_SEL  in  P_SW  readback channel select
- O_A  out  P_CH  conditioned A rising-edge strobe, 1 cycle
- O_Z  out  P_CH  conditioned Z rising-edge strobe, 1 cycle
- O_ACTIVE  out  P_CH  channel in ST_ACTIVE
- O_CAP_VLD  out  P_CH  capture strobe, 1 cycle
- O_OVF  out  P_CH  sticky saturation flag
- O_CNT  out  P_CH*P_CW  captured counts; channel i at [i*P_CW +: P_CW]
- O_CNT_SEL  out  P_CW  captured count of channel I_SEL, registered

## Operation
- Per-channel FSM (RST → ST_IDLE):
  - ST_IDLE: counter held at 0. I_ARM=1 → ST_WAIT_Z.
  - ST_WAIT_Z: A edges ignored. Z edge → ST_ACTIVE, counter cleared to 0; no capture.
  - ST_ACTIVE: each A edge increments the counter. Each Z edge copies the counter (including a same-cycle A edge) into the channel's O_CNT slice and pulses O_CAP_VLD. The counter restarts at 0, or at 1 if an A edge coincides.
  - I_ARM=0 in any state → ST_IDLE next cycle. Counter and O_OVF are cleared; O_CNT slices hold their last captured value.
- Saturation: the counter stops at all-ones (2^P_CW−1); further A edges set O_OVF. O_OVF is cleared only by RST or I_ARM=0. Captures still occur and carry the saturated value.
- Channels are fully independent apart from I_ARM. Simultaneous events on different channels have no interaction.
- O_CNT_SEL: registered mux of O_CNT by I_SEL. I_SEL ≥ P_CH yields 0.
- RST mid-operation: all state, counters and outputs return to reset values on the next CLK edge, regardless of I_ARM.

## Timing
- Reset values: every output is 0, including O_CNT, O_CNT_SEL and O_OVF.
- Edge detection: a rising edge is one sample 0 followed by one sample 1 of the conditioned input. The minimum pulse high and low time is 1 CLK (3 CLK with synchroniser).
- Latency, from the first CLK edge sampling the input high:
  - with synchroniser: O_A/O_Z strobe at +2 cycles; counter/O_CNT/O_CAP_VLD update at +3.
  - without synchroniser: strobe at +0 cycles (combinational from the edge register); counter update at +1.
- O_CNT_SEL lags O_CNT or I_SEL changes by 1 cycle.
- I_ARM is sampled directly; the design assumes it is synchronous to CLK.

## Configuration
- ENC_CNT_SYNC_EN defined: a 2-flop synchroniser precedes the edge detector on every I_A/I_Z bit, and the latencies above include +2 cycles.
- ENC_CNT_SYNC_EN undefined: I_A/I_Z are treated as CLK-synchronous with no synchroniser flops, for on-chip pulse sources.

## Structure
- Package enc_cnt_pkg holds:
  - the state typedef enum {ST_IDLE, ST_WAIT_Z, ST_ACTIVE};
  - the localparam C_SYNC_STAGES (2 or 0 per macro).
- Sub-module enc_cnt_ch implements one channel: conditioning, edge detection, FSM, counter, capture and OVF. It is instantiated P_CH times in a generate loop.
- The top level holds only the generate loop and the O_CNT_SEL mux register.

## Test plan
- RST with I_ARM=1 and pulses active → all outputs 0 the next cycle; after release, the FSM restarts in ST_IDLE and reaches ST_WAIT_Z one cycle later.
- P_CH=2, I_ARM=1, Z every 3 A pulses, 5 arm/disarm cycles of 500 A each → every O_CAP_VLD carries 3 on both channels. The first Z after arm causes no capture.
- A and Z edges in the same cycle on ch0 after 7 prior A edges → capture 8, next capture (2 more A) 3.
- P_CW=8, 300 A edges without Z then Z → capture 255, O_OVF=1. O_OVF stays set until I_ARM=0, then reads 0.
- I_ARM dropped mid-revolution after 40 A → O_ACTIVE=0, O_CNT retains the prior capture. A re-arm with no Z yields no counting.
- I_SEL sweep 0,1,2 with P_CH=2 → O_CNT_SEL equals ch0, then ch1, then 0, each one cycle after the select changes.

Source files
------------

// File: rtl/enc_cnt_pkg.sv
// enc_cnt_pkg: shared types and constants for the enc_cnt_multi encoder counter.
//   state_t       : per-channel FSM states
//   C_SYNC_STAGES : synchroniser depth ahead of the edge detectors
//   Build macro ENC_CNT_SYNC_EN selects a 2-flop synchroniser (2) or none (0).
package enc_cnt_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_Z, ST_ACTIVE} state_t;

`ifdef ENC_CNT_SYNC_EN
    localparam int C_SYNC_STAGES = 2;
`else
    localparam int C_SYNC_STAGES = 0;
`endif

endpackage

// File: rtl/enc_cnt_ch.sv
// enc_cnt_ch: one encoder channel - input conditioning, rising-edge detection,
//             arm/index FSM, saturating pulse counter, per-revolution capture.
//   CLK       in  system clock
//   RST       in  synchronous active-high reset
//   I_ARM     in  global arm level
//   I_A, I_Z  in  raw encoder A / index pulse
//   O_A, O_Z  out conditioned rising-edge strobes
//   O_ACTIVE  out channel is counting (ST_ACTIVE)
//   O_CAP_VLD out one-cycle capture strobe
//   O_OVF     out sticky saturation flag
//   O_CNT     out last captured count
//   Build macro ENC_CNT_SYNC_EN (via enc_cnt_pkg) inserts 2 synchroniser flops.
module enc_cnt_ch
    import enc_cnt_pkg::*;
#(
    parameter int P_CW = 64
)(
    input  logic            CLK,
    input  logic            RST,
    input  logic            I_ARM,
    input  logic            I_A,
    input  logic            I_Z,
    output logic            O_A,
    output logic            O_Z,
    output logic            O_ACTIVE,
    output logic            O_CAP_VLD,
    output logic            O_OVF,
    output logic [P_CW-1:0] O_CNT
);

    // Shift chain: synchroniser stages, then the edge register, then its
    // one-cycle-old copy; the strobe compares the last two taps.
    localparam int C_N = C_SYNC_STAGES + 1;

    logic [C_N:0]    r_a_p, r_z_p;
    state_t          r_state, w_state_nx;
    logic [P_CW-1:0] r_cnt, w_cnt_nx, r_cap, w_cap_nx, w_cnt_a;
    logic            r_vld, w_vld_nx, r_ovf, w_ovf_nx;
    logic            w_a, w_z, w_sat;

    assign w_a     = r_a_p[C_N-1] & ~r_a_p[C_N];
    assign w_z     = r_z_p[C_N-1] & ~r_z_p[C_N];
    assign w_sat   = &r_cnt;
    // Count including this cycle's A edge, pinned at all-ones.
    assign w_cnt_a = (w_a && !w_sat) ? r_cnt + P_CW'(1) : r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a_p   <= '0;
            r_z_p   <= '0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cap   <= '0;
            r_vld   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_a_p   <= {r_a_p[C_N-1:0], I_A};
            r_z_p   <= {r_z_p[C_N-1:0], I_Z};
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cap   <= w_cap_nx;
            r_vld   <= w_vld_nx;
            r_ovf   <= w_ovf_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cap_nx   = r_cap;
        w_vld_nx   = 1'b0;
        w_ovf_nx   = r_ovf;
        if (!I_ARM) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_ovf_nx   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_WAIT_Z;
                    w_cnt_nx   = '0;
                end
                ST_WAIT_Z: begin
                    w_state_nx = w_z ? ST_ACTIVE : ST_WAIT_Z;
                    w_cnt_nx   = '0;
                end
                ST_ACTIVE: begin
                    w_ovf_nx = r_ovf | (w_a & w_sat);
                    w_cap_nx = w_z ? w_cnt_a : r_cap;
                    w_vld_nx = w_z;
                    // A new revolution starts at 1 when an A edge shares the index cycle.
                    w_cnt_nx = w_z ? {{(P_CW-1){1'b0}}, w_a} : w_cnt_a;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign O_A       = w_a;
    assign O_Z       = w_z;
    assign O_ACTIVE  = (r_state == ST_ACTIVE);
    assign O_CAP_VLD = r_vld;
    assign O_OVF     = r_ovf;
    assign O_CNT     = r_cap;

endmodule

// File: rtl/enc_cnt_multi.sv
// enc_cnt_multi: P_CH-channel incremental-encoder pulse counter with registered
//                single-channel readback.
//   CLK        in  system clock
//   RST        in  synchronous active-high reset
//   I_ARM      in  global arm level, shared by all channels
//   I_A, I_Z   in  [P_CH] encoder A / index pulses
//   I_SEL      in  [P_SW] readback channel select
//   O_A, O_Z   out [P_CH] conditioned rising-edge strobes
//   O_ACTIVE   out [P_CH] channel counting
//   O_CAP_VLD  out [P_CH] capture strobes
//   O_OVF      out [P_CH] sticky saturation flags
//   O_CNT      out [P_CH*P_CW] captured counts, channel i at [i*P_CW +: P_CW]
//   O_CNT_SEL  out [P_CW] captured count of channel I_SEL (0 when out of range)
//   Build macro ENC_CNT_SYNC_EN inserts a 2-flop synchroniser on every I_A/I_Z bit.
module enc_cnt_multi
    import enc_cnt_pkg::*;
#(
    parameter  int P_CH = 2,
    parameter  int P_CW = 64,
    localparam int P_SW = (P_CH > 1) ? $clog2(P_CH) : 1
)(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 I_ARM,
    input  logic [P_CH-1:0]      I_A,
    input  logic [P_CH-1:0]      I_Z,
    input  logic [P_SW-1:0]      I_SEL,
    output logic [P_CH-1:0]      O_A,
    output logic [P_CH-1:0]      O_Z,
    output logic [P_CH-1:0]      O_ACTIVE,
    output logic [P_CH-1:0]      O_CAP_VLD,
    output logic [P_CH-1:0]      O_OVF,
    output logic [P_CH*P_CW-1:0] O_CNT,
    output logic [P_CW-1:0]      O_CNT_SEL
);

    // Select table padded to the full I_SEL range; unused codes read as 0.
    logic [P_CW-1:0] w_cnt_tab [2**P_SW];
    logic [P_CW-1:0] r_cnt_sel;

    for (genvar i = 0; i < P_CH; i++) begin : g_ch
        enc_cnt_ch #(.P_CW(P_CW)) u_ch (
            .CLK       (CLK),
            .RST       (RST),
            .I_ARM     (I_ARM),
            .I_A       (I_A[i]),
            .I_Z       (I_Z[i]),
            .O_A       (O_A[i]),
            .O_Z       (O_Z[i]),
            .O_ACTIVE  (O_ACTIVE[i]),
            .O_CAP_VLD (O_CAP_VLD[i]),
            .O_OVF     (O_OVF[i]),
            .O_CNT     (O_CNT[i*P_CW +: P_CW])
        );
        assign w_cnt_tab[i] = O_CNT[i*P_CW +: P_CW];
    end

    for (genvar i = P_CH; i < 2**P_SW; i++) begin : g_pad
        assign w_cnt_tab[i] = '0;
    end

    always_ff @(posedge CLK) begin
        r_cnt_sel <= RST ? '0 : w_cnt_tab[I_SEL];
    end

    assign O_CNT_SEL = r_cnt_sel;

endmodule

// File: tb/tb_enc_cnt_multi.sv
// tb_enc_cnt_multi: directed bench with a behavioural per-cycle model for enc_cnt_multi.
module tb_enc_cnt_multi;
    import enc_cnt_pkg::*;

    localparam int     CH   = 3;
    localparam int     CW   = 8;
    localparam int     SW   = 2;
    localparam int     L    = C_SYNC_STAGES;
    localparam int     PW   = L + 1;
    localparam longint MAXV = (64'd1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, arm;
    logic [CH-1:0]    a, z;
    logic [SW-1:0]    sel;
    logic [CH-1:0]    o_a, o_z, o_act, o_vld, o_ovf;
    logic [CH*CW-1:0] o_cnt;
    logic [CW-1:0]    o_sel;
    int n_cmp = 0;
    int n_err = 0;
    int caps0 = 0;
    bit started = 1'b0;

    enc_cnt_multi #(.P_CH(CH), .P_CW(CW)) dut (
        .CLK(clk), .RST(rst), .I_ARM(arm), .I_A(a), .I_Z(z), .I_SEL(sel),
        .O_A(o_a), .O_Z(o_z), .O_ACTIVE(o_act), .O_CAP_VLD(o_vld),
        .O_OVF(o_ovf), .O_CNT(o_cnt), .O_CNT_SEL(o_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: input history per channel, mode 0=disarmed 1=awaiting index 2=counting.
    logic [L+1:0]  ha [CH];
    logic [L+1:0]  hz [CH];
    int            mode [CH];
    longint        cnt [CH];
    logic [CW-1:0] cap [CH];
    logic [CH-1:0] e_vld, e_ovf;
    logic [CW-1:0] e_sel;
    logic          sa, sz;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                ha[c] = '0; hz[c] = '0; mode[c] = 0; cnt[c] = 0; cap[c] = '0;
            end
            e_vld = '0; e_ovf = '0; e_sel = '0;
        end else begin
            e_sel = '0;
            if (int'(sel) < CH) e_sel = cap[sel];
            for (int c = 0; c < CH; c++) begin
                sa = ha[c][L] & ~ha[c][L+1];
                sz = hz[c][L] & ~hz[c][L+1];
                e_vld[c] = 1'b0;
                if (!arm) begin
                    mode[c] = 0; cnt[c] = 0; e_ovf[c] = 1'b0;
                end else if (mode[c] == 0) begin
                    mode[c] = 1;
                end else if (mode[c] == 1) begin
                    if (sz) begin mode[c] = 2; cnt[c] = 0; end
                end else begin
                    if (sa) begin
                        if (cnt[c] == MAXV) e_ovf[c] = 1'b1;
                        else cnt[c] = cnt[c] + 1;
                    end
                    if (sz) begin
                        cap[c] = cnt[c][CW-1:0];
                        e_vld[c] = 1'b1;
                        cnt[c] = sa ? 1 : 0;
                    end
                end
                ha[c] = {ha[c][L:0], a[c]};
                hz[c] = {hz[c][L:0], z[c]};
            end
        end
    end

    logic [CH-1:0]    ea, ez, eact;
    logic [CH*CW-1:0] ecnt;

    always @(negedge clk) begin
        if (started) begin
            for (int c = 0; c < CH; c++) begin
                ea[c]   = ha[c][L] & ~ha[c][L+1];
                ez[c]   = hz[c][L] & ~hz[c][L+1];
                eact[c] = (mode[c] == 2);
                ecnt[c*CW +: CW] = cap[c];
            end
            check("o_a", 64'(o_a), 64'(ea));
            check("o_z", 64'(o_z), 64'(ez));
            check("o_active", 64'(o_act), 64'(eact));
            check("o_cap_vld", 64'(o_vld), 64'(e_vld));
            check("o_ovf", 64'(o_ovf), 64'(e_ovf));
            check("o_cnt", 64'(o_cnt), 64'(ecnt));
            check("o_cnt_sel", 64'(o_sel), 64'(e_sel));
            if (o_vld[0]) caps0++;
        end
    end

    task automatic tick(input logic ar, input logic [CH-1:0] av, input logic [CH-1:0] zv);
        arm = ar; a = av; z = zv;
        @(posedge clk); #1;
    endtask

    task automatic pulse(input logic [CH-1:0] av, input logic [CH-1:0] zv);
        repeat (PW) tick(1'b1, av, zv);
        repeat (PW) tick(1'b1, '0, '0);
    endtask

    task automatic arm_up(input logic [CH-1:0] zv);
        repeat (2) tick(1'b1, '0, '0);
        pulse('0, zv);
    endtask

    task automatic z_cap(input logic [CH-1:0] av, input logic [CH-1:0] zv, input int ch,
                         input logic [CW-1:0] ev, input string nm);
        bit found = 1'b0;
        repeat (PW) tick(1'b1, av, zv);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, '0, '0);
            if (!found && o_vld[ch]) begin
                found = 1'b1;
                check(nm, 64'(o_cnt[ch*CW +: CW]), 64'(ev));
            end
        end
        if (!found) check({nm, "_seen"}, 64'd0, 64'd1);
    endtask

    int c_before;

    initial begin
        rst = 1'b1; arm = 1'b1; a = '1; z = '1; sel = '0;
        @(posedge clk); #1;
        started = 1'b1;
        check("rst_cnt", 64'(o_cnt), 64'd0);
        check("rst_sel", 64'(o_sel), 64'd0);
        check("rst_act", 64'(o_act), 64'd0);
        check("rst_ovf", 64'(o_ovf), 64'd0);
        check("rst_vld", 64'(o_vld), 64'd0);
        tick(1'b1, '1, '1);
        rst = 1'b0;
        tick(1'b1, '0, '0);

        c_before = caps0;
        for (int r = 0; r < 5; r++) begin
            arm_up('1);
            for (int k = 1; k <= 500; k++) begin
                pulse('1, '0);
                if (k % 3 == 0) pulse('0, '1);
            end
            repeat (2) tick(1'b0, '0, '0);
        end
        check("rev_caps", 64'(caps0 - c_before), 64'd830);
        check("rev_cnt", 64'(o_cnt), 64'h030303);

        arm_up(3'b001);
        repeat (7) pulse(3'b001, '0);
        z_cap(3'b001, 3'b001, 0, 8'd8, "cap_coinc");
        repeat (2) pulse(3'b001, '0);
        z_cap('0, 3'b001, 0, 8'd3, "cap_after_coinc");
        tick(1'b0, '0, '0);

        arm_up(3'b010);
        repeat (300) pulse(3'b010, '0);
        check("ovf_set", 64'(o_ovf), 64'b010);
        z_cap('0, 3'b010, 1, 8'd255, "cap_sat");
        check("ovf_hold", 64'(o_ovf), 64'b010);
        tick(1'b0, '0, '0);
        check("ovf_clr", 64'(o_ovf), 64'd0);

        arm_up(3'b001);
        repeat (4) pulse(3'b001, '0);
        z_cap('0, 3'b001, 0, 8'd4, "cap_four");
        repeat (40) pulse(3'b001, '0);
        tick(1'b0, '0, '0);
        check("disarm_act", 64'(o_act), 64'd0);
        check("disarm_hold", 64'(o_cnt[CW-1:0]), 64'd4);
        repeat (2) tick(1'b1, '0, '0);
        repeat (5) pulse(3'b001, '0);
        check("rearm_idle", 64'(o_act), 64'd0);
        tick(1'b0, '0, '0);

        sel = 2'd0; tick(1'b0, '0, '0);
        check("sel0", 64'(o_sel), 64'd4);
        sel = 2'd1; #1;
        check("sel_lag", 64'(o_sel), 64'd4);
        tick(1'b0, '0, '0);
        check("sel1", 64'(o_sel), 64'd255);
        sel = 2'd2; tick(1'b0, '0, '0);
        check("sel2", 64'(o_sel), 64'd3);
        sel = 2'd3; tick(1'b0, '0, '0);
        check("sel3", 64'(o_sel), 64'd0);

        sel = 2'd0;
        arm_up('1);
        repeat (3) pulse('1, '0);
        rst = 1'b1;
        tick(1'b1, '1, '1);
        check("mid_rst_cnt", 64'(o_cnt), 64'd0);
        check("mid_rst_sel", 64'(o_sel), 64'd0);
        check("mid_rst_act", 64'(o_act), 64'd0);
        check("mid_rst_ovf", 64'(o_ovf), 64'd0);
        check("mid_rst_vld", 64'(o_vld), 64'd0);
        rst = 1'b0;
        repeat (3) tick(1'b0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
